// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one registered W-bit adder among N_REQ requesters.
// Define ADDER_SAT_EN to saturate the sum and report overflow in rsp_sum[W].
module adder_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int W     = 4,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  output logic [N_REQ-1:0]   req_ready,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [W:0]         rsp_sum,
  output logic               busy,
  output logic [7:0]         done_cnt
);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] rr_ptr, grant_id, winner, sel, rr_nxt;
  logic           found;
  logic [W-1:0]   op_a, op_b;
  logic [W:0]     sum_full, sum_res;
  int unsigned    idx;

  // Search upward from rr_ptr, wrapping, for the first pending requester.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    sel    = '0;
    for (int unsigned k = 0; k < unsigned'(N_REQ); k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= unsigned'(N_REQ)) idx = idx - unsigned'(N_REQ);
      sel = idx[IDW-1:0];
      if (!found && req_valid[sel]) begin
        found  = 1'b1;
        winner = sel;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && found && rst_n) req_ready[winner] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = CALC;
      CALC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  assign busy     = (state != IDLE);
  assign sum_full = {1'b0, op_a} + {1'b0, op_b};
  assign rr_nxt   = (grant_id == IDW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;

`ifdef ADDER_SAT_EN
  // All-ones fill sets the overflow flag and saturates the low W bits together.
  assign sum_res = sum_full[W] ? '1 : sum_full;
`else
  assign sum_res = sum_full;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      grant_id  <= '0;
      op_a      <= '0;
      op_b      <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      done_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            op_a     <= req_a[32'(winner)*W +: W];
            op_b     <= req_b[32'(winner)*W +: W];
            grant_id <= winner;
          end
        end
        CALC: begin
          rsp_sum   <= sum_res;
          rsp_id    <= grant_id;
          rsp_valid <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            done_cnt  <= done_cnt + 8'd1;
            rr_ptr    <= rr_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Scoreboard bench for adder_share_arbiter: directed vectors, queue-based response checking.
module tb_adder_share_arbiter;

  localparam int N_REQ = 4;
  localparam int W     = 4;
  localparam int IDW   = 2;

`ifdef ADDER_SAT_EN
  localparam logic [4:0] EXP_OVF = 5'h1F;
`else
  localparam logic [4:0] EXP_OVF = 5'h11;
`endif

  logic               clk = 1'b0;
  logic               rst_n;
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ*W-1:0] req_a, req_b;
  logic [N_REQ-1:0]   req_ready;
  logic               rsp_valid, rsp_ready, busy;
  logic [IDW-1:0]     rsp_id;
  logic [W:0]         rsp_sum;
  logic [7:0]         done_cnt;

  typedef struct {
    logic [IDW-1:0] id;
    logic [W:0]     sum;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_rsp = 0;

  adder_share_arbiter #(.N_REQ(N_REQ), .W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
    .busy(busy), .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [IDW-1:0] id, input logic [W:0] sum);
    exp_t e;
    e.id  = id;
    e.sum = sum;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(input int target, input int budget);
    for (int k = 0; k < budget; k++) begin
      if (n_rsp >= target) break;
      step();
    end
    check("rsp_count", n_rsp, target);
  endtask

  // Monitor: every accepted response is matched against the head of the queue.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_rsp: got id %0h sum %0h expected none", rsp_id, rsp_sum);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp_id", rsp_id, e.id);
        check("rsp_sum", rsp_sum, e.sum);
      end
      n_rsp++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;

    // Reset then idle
    repeat (10) step();
    @(negedge clk);
    check("idle_req_ready", req_ready, 4'b0000);
    check("idle_rsp_valid", rsp_valid, 1'b0);
    check("idle_busy", busy, 1'b0);
    check("idle_done_cnt", done_cnt, 8'd0);

    // Single request from requester 1: 3 + 4
    step();
    req_valid = 4'b0010; req_a = 16'h0030; req_b = 16'h0040; rsp_ready = 1'b1;
    push(2'd1, 5'h07);
    @(negedge clk);
    check("single_ready_c0", req_ready, 4'b0010);
    check("single_busy_c0", busy, 1'b0);
    step();
    req_valid = '0;
    @(negedge clk);
    check("single_valid_c1", rsp_valid, 1'b0);
    check("single_busy_c1", busy, 1'b1);
    check("single_ready_c1", req_ready, 4'b0000);
    step();
    @(negedge clk);
    check("single_valid_c2", rsp_valid, 1'b1);
    step();
    @(negedge clk);
    check("single_done_cnt", done_cnt, 8'd1);
    check("single_valid_after", rsp_valid, 1'b0);

    // Overflow on requester 0: F + 2 (rr_ptr=2 wraps to 0)
    step();
    req_valid = 4'b0001; req_a = 16'h000F; req_b = 16'h0002;
    push(2'd0, EXP_OVF);
    @(negedge clk);
    check("ovf_ready_c0", req_ready, 4'b0001);
    step();
    req_valid = '0;
    wait_rsp(2, 20);
    check("ovf_done_cnt", done_cnt, 8'd2);

    // Reset asserted during CALC discards the transaction
    req_valid = 4'b0100; req_a = 16'h0700; req_b = 16'h0100;
    @(negedge clk);
    check("rstcalc_ready_c0", req_ready, 4'b0100);
    step();
    check("rstcalc_busy_pre", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rstcalc_rsp_valid", rsp_valid, 1'b0);
    check("rstcalc_busy", busy, 1'b0);
    check("rstcalc_req_ready", req_ready, 4'b0000);
    check("rstcalc_done_cnt", done_cnt, 8'd0);
    check("rstcalc_rsp_sum", rsp_sum, 5'h00);
    check("rstcalc_rsp_id", rsp_id, 2'd0);
    req_valid = '0;
    @(negedge clk); rst_n = 1'b1;
    repeat (6) step();
    @(negedge clk);
    check("rstcalc_no_stale", rsp_valid, 1'b0);
    check("rstcalc_rsp_count", n_rsp, 2);

    // Round-robin with all requesters held valid; rr_ptr must be back at 0
    step();
    req_valid = 4'b1111; req_a = 16'h4321; req_b = 16'h8765;
    push(2'd0, 5'h06); push(2'd1, 5'h08); push(2'd2, 5'h0A); push(2'd3, 5'h0C);
    push(2'd0, 5'h06);
    @(negedge clk);
    check("rr_first_ready", req_ready, 4'b0001);
    step();
    wait_rsp(7, 40);
    req_valid = '0;
    check("rr_done_cnt", done_cnt, 8'd5);

    // Requester 2 arrives while 1 is being served and is granted next
    req_valid = 4'b0010; req_a = 16'h0650; req_b = 16'h0620;
    push(2'd1, 5'h07); push(2'd2, 5'h0C);
    @(negedge clk);
    check("late_ready_c0", req_ready, 4'b0010);
    step();
    req_valid = 4'b0100;
    @(negedge clk);
    check("late_ready_calc", req_ready, 4'b0000);
    step();
    wait_rsp(8, 20);
    @(negedge clk);
    check("late_ready_next", req_ready, 4'b0100);
    step();
    req_valid = '0;
    wait_rsp(9, 20);
    check("late_done_cnt", done_cnt, 8'd7);

    // Backpressure: response held for 5 cycles with other requests pending
    req_valid = 4'b1000; req_a = 16'h9000; req_b = 16'h5000; rsp_ready = 1'b0;
    push(2'd3, 5'h0E);
    @(negedge clk);
    check("bp_ready_c0", req_ready, 4'b1000);
    step();
    req_valid = 4'b0111;
    step();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_rsp_valid", rsp_valid, 1'b1);
      check("bp_rsp_id", rsp_id, 2'd3);
      check("bp_rsp_sum", rsp_sum, 5'h0E);
      check("bp_req_ready", req_ready, 4'b0000);
      step();
    end
    rsp_ready = 1'b1; req_valid = '0;
    wait_rsp(10, 10);
    check("bp_done_cnt", done_cnt, 8'd8);

    // Continuous traffic until done_cnt wraps 255 -> 0
    req_valid = 4'b1111; req_a = 16'h4321; req_b = 16'h8765;
    for (int k = 0; k < 248; k++) begin
      case (k % 4)
        0:       push(2'd0, 5'h06);
        1:       push(2'd1, 5'h08);
        2:       push(2'd2, 5'h0A);
        default: push(2'd3, 5'h0C);
      endcase
    end
    wait_rsp(258, 248 * 3 + 30);
    req_valid = '0;
    check("wrap_done_cnt", done_cnt, 8'd0);

    repeat (5) step();
    check("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
